// File: rtl/systolic_array_param.sv
// systolic_array_param
//   Parametrised ROWS x COLS output-stationary systolic multiply engine that
//   computes C = A x B. A is ROWS x K and B is K x COLS. K is programmable
//   at run time through k_len.
//   The feeder supplies one unskewed A column and one unskewed B row per beat.
//   Internal skew registers align the operands. Cycles without a handshake
//   inject zeros, so bubbles do not disturb the alignment.
//
// Optional build macro: SYSARR_SAT_EN
//   When defined, every accumulator saturates instead of wrapping, and a
//   sticky sat_flag output is added.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   start, k_len    begin a product with inner dimension k_len (IDLE only)
//   in_valid        feeder beat valid
//   in_ready        beat accepted when in_valid is also high (LOAD only)
//   a_col           A[i][k] in lane i, bits [i*DW +: DW]
//   b_row           B[k][j] in lane j, bits [j*DW +: DW]
//   busy            high in LOAD and DRAIN
//   done            one-cycle pulse when all results are final
//   rd_row, rd_col  result select
//   rd_data         accumulator of PE(rd_row, rd_col), combinational
//   sat_flag        (SYSARR_SAT_EN only) sticky; set when any PE clamps
module systolic_array_param #(
  parameter int ROWS        = 4,
  parameter int COLS        = 4,
  parameter int DW          = 32,
  parameter int ACC_W       = 64,
  parameter int KW          = 8,
  parameter int SIGNED_MODE = 0,
  localparam int RRW        = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CRW        = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [KW-1:0]        k_len,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ROWS*DW-1:0]   a_col,
  input  logic [COLS*DW-1:0]   b_row,
  output logic                 busy,
  output logic                 done,
  input  logic [RRW-1:0]       rd_row,
  input  logic [CRW-1:0]       rd_col,
  output logic [ACC_W-1:0]     rd_data
`ifdef SYSARR_SAT_EN
  ,
  output logic                 sat_flag
`endif
);

  localparam int DRAIN_INIT = ROWS + COLS - 2;
  localparam int DCW        = $clog2(ROWS + COLS);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   klen_q, klen_d;
  logic [KW-1:0]   beat_q, beat_d;
  logic [DCW-1:0]  drain_q, drain_d;

  logic clear;
  logic fire;
  logic [ROWS*DW-1:0] a_feed, a_edge;
  logic [COLS*DW-1:0] b_feed, b_edge;
  logic [ROWS*COLS*DW-1:0]    a_pass, b_pass;
  logic [ROWS*COLS*ACC_W-1:0] acc_flat;

  assign clear  = (state_q == S_IDLE) && start;
  assign fire   = (state_q == S_LOAD) && in_valid;
  assign a_feed = fire ? a_col : '0;
  assign b_feed = fire ? b_row : '0;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      klen_q  <= '0;
      beat_q  <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      klen_q  <= klen_d;
      beat_q  <= beat_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    klen_d   = klen_q;
    beat_d   = beat_q;
    drain_d  = drain_q;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          beat_d = '0;
          if (k_len != '0) begin
            klen_d  = k_len;
            state_d = S_LOAD;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          if (beat_q == klen_q - KW'(1)) begin
            beat_d  = '0;
            drain_d = DCW'(DRAIN_INIT);
            // A 1x1 array has nothing in flight once the last beat is in.
            state_d = (DRAIN_INIT == 0) ? S_DONE : S_DRAIN;
          end else begin
            beat_d = beat_q + KW'(1);
          end
        end
      end
      S_DRAIN: begin
        busy    = 1'b1;
        drain_d = drain_q - DCW'(1);
        if (drain_q <= DCW'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- input skew ----------------
  // Lane i is delayed by i registers.
  for (genvar i = 0; i < ROWS; i++) begin : g_askew
    if (i == 0) begin : g_direct
      assign a_edge[0 +: DW] = a_feed[0 +: DW];
    end else begin : g_sr
      logic [DW-1:0] sr_q [i];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int unsigned n = 0; n < i; n++) sr_q[n] <= '0;
        end else begin
          sr_q[0] <= a_feed[i*DW +: DW];
          for (int unsigned n = 1; n < i; n++) sr_q[n] <= sr_q[n-1];
        end
      end
      assign a_edge[i*DW +: DW] = sr_q[i-1];
    end
  end

  for (genvar j = 0; j < COLS; j++) begin : g_bskew
    if (j == 0) begin : g_direct
      assign b_edge[0 +: DW] = b_feed[0 +: DW];
    end else begin : g_sr
      logic [DW-1:0] sr_q [j];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int unsigned n = 0; n < j; n++) sr_q[n] <= '0;
        end else begin
          sr_q[0] <= b_feed[j*DW +: DW];
          for (int unsigned n = 1; n < j; n++) sr_q[n] <= sr_q[n-1];
        end
      end
      assign b_edge[j*DW +: DW] = sr_q[j-1];
    end
  end

  // ---------------- PE grid ----------------
`ifdef SYSARR_SAT_EN
  logic [ROWS*COLS-1:0] sat_hits;
`endif

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [DW-1:0]    a_in, b_in;
      logic [2*DW-1:0]  prod;
      logic [ACC_W-1:0] prod_ext, acc_q, acc_d;

      if (c == 0) begin : g_aw
        assign a_in = a_edge[r*DW +: DW];
      end else begin : g_ap
        assign a_in = a_pass[(r*COLS + c - 1)*DW +: DW];
      end
      if (r == 0) begin : g_bn
        assign b_in = b_edge[c*DW +: DW];
      end else begin : g_bp
        assign b_in = b_pass[((r-1)*COLS + c)*DW +: DW];
      end

      // The east/south pass registers on the array edge have no consumer.
      if (c < COLS - 1) begin : g_aq
        logic [DW-1:0] a_q;
        always_ff @(posedge clk or posedge rst) begin
          if (rst) a_q <= '0;
          else     a_q <= a_in;
        end
        assign a_pass[(r*COLS + c)*DW +: DW] = a_q;
      end else begin : g_anone
        assign a_pass[(r*COLS + c)*DW +: DW] = '0;
      end
      if (r < ROWS - 1) begin : g_bq
        logic [DW-1:0] b_q;
        always_ff @(posedge clk or posedge rst) begin
          if (rst) b_q <= '0;
          else     b_q <= b_in;
        end
        assign b_pass[(r*COLS + c)*DW +: DW] = b_q;
      end else begin : g_bnone
        assign b_pass[(r*COLS + c)*DW +: DW] = '0;
      end

      if (SIGNED_MODE != 0) begin : g_smul
        assign prod     = (2*DW)'($signed(a_in)) * (2*DW)'($signed(b_in));
        assign prod_ext = ACC_W'($signed(prod));
      end else begin : g_umul
        assign prod     = (2*DW)'(a_in) * (2*DW)'(b_in);
        assign prod_ext = ACC_W'(prod);
      end

`ifdef SYSARR_SAT_EN
      logic sat_hit;
      logic carry;
      always_comb begin
        sat_hit = 1'b0;
        carry   = 1'b0;
        acc_d   = '0;
        if (SIGNED_MODE != 0) begin
          acc_d = acc_q + prod_ext;
          // Overflow only when both addends share a sign and the sum flips it.
          if ((acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
              (acc_d[ACC_W-1] != acc_q[ACC_W-1])) begin
            sat_hit = 1'b1;
            acc_d   = acc_q[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                     : {1'b0, {(ACC_W-1){1'b1}}};
          end
        end else begin
          {carry, acc_d} = {1'b0, acc_q} + {1'b0, prod_ext};
          if (carry) begin
            sat_hit = 1'b1;
            acc_d   = '1;
          end
        end
      end
      assign sat_hits[r*COLS + c] = sat_hit;
`else
      assign acc_d = acc_q + prod_ext;
`endif

      always_ff @(posedge clk or posedge rst) begin
        if (rst)        acc_q <= '0;
        else if (clear) acc_q <= '0;
        else            acc_q <= acc_d;
      end
      assign acc_flat[(r*COLS + c)*ACC_W +: ACC_W] = acc_q;
    end
  end

`ifdef SYSARR_SAT_EN
  logic sat_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            sat_q <= 1'b0;
    else if (clear)     sat_q <= 1'b0;
    else if (|sat_hits) sat_q <= 1'b1;
  end
  assign sat_flag = sat_q;
`endif

  // ---------------- result read port ----------------
  always_comb begin
    rd_data = '0;
    for (int unsigned n = 0; n < ROWS*COLS; n++) begin
      if ((32'(rd_row) == n / COLS) && (32'(rd_col) == n % COLS))
        rd_data = acc_flat[n*ACC_W +: ACC_W];
    end
  end

endmodule

// File: tb/tb_systolic_array_param.sv
// Bench for systolic_array_param: three 4x4 instances share one stimulus
// stream (32/64-bit unsigned, 8/16-bit signed, 8/16-bit unsigned) and are
// compared with a plain matrix-product reference model.
module tb_systolic_array_param;
  localparam int R = 4;
  localparam int C = 4;
  localparam int KMAX = 16;
`ifdef SYSARR_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, in_valid;
  logic [7:0] k_len;
  logic [R*32-1:0] a32;
  logic [C*32-1:0] b32;
  logic [R*8-1:0]  a8;
  logic [C*8-1:0]  b8;
  logic [1:0] rd_row, rd_col;
  logic in_ready0, busy0, done0, in_ready1, busy1, done1, in_ready2, busy2, done2;
  logic [63:0] rd0;
  logic [15:0] rd1, rd2;
`ifdef SYSARR_SAT_EN
  logic sat0, sat1, sat2;
`endif

  always_comb begin
    a8 = '0;
    b8 = '0;
    for (int i = 0; i < R; i++) a8[i*8 +: 8] = a32[i*32 +: 8];
    for (int j = 0; j < C; j++) b8[j*8 +: 8] = b32[j*32 +: 8];
  end

  systolic_array_param #(.ROWS(R), .COLS(C), .DW(32), .ACC_W(64), .KW(8), .SIGNED_MODE(0)) u0 (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .in_valid(in_valid),
    .in_ready(in_ready0), .a_col(a32), .b_row(b32), .busy(busy0), .done(done0),
    .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd0)
`ifdef SYSARR_SAT_EN
    , .sat_flag(sat0)
`endif
  );
  systolic_array_param #(.ROWS(R), .COLS(C), .DW(8), .ACC_W(16), .KW(8), .SIGNED_MODE(1)) u1 (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .in_valid(in_valid),
    .in_ready(in_ready1), .a_col(a8), .b_row(b8), .busy(busy1), .done(done1),
    .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd1)
`ifdef SYSARR_SAT_EN
    , .sat_flag(sat1)
`endif
  );
  systolic_array_param #(.ROWS(R), .COLS(C), .DW(8), .ACC_W(16), .KW(8), .SIGNED_MODE(0)) u2 (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .in_valid(in_valid),
    .in_ready(in_ready2), .a_col(a8), .b_row(b8), .busy(busy2), .done(done2),
    .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd2)
`ifdef SYSARR_SAT_EN
    , .sat_flag(sat2)
`endif
  );

  int n_chk = 0;
  int n_pass = 0;

  logic [31:0] Am [R][KMAX];
  logic [31:0] Bm [KMAX][C];
  logic [63:0] e0 [R][C];
  logic [15:0] e1 [R][C];
  logic [15:0] e2 [R][C];
  bit es0, es1, es2;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // Reference: C = A x B accumulated beat by beat in k order, with
  // wrap or clamp applied after every addition.
  task automatic model(input int k);
    logic [64:0] s;
    logic [63:0] acc0;
    logic [15:0] t16;
    logic [7:0]  a8s, b8s;
    longint acc1, acc2;
    es0 = 0; es1 = 0; es2 = 0;
    for (int i = 0; i < R; i++) begin
      for (int j = 0; j < C; j++) begin
        acc0 = '0; acc1 = 0; acc2 = 0;
        for (int n = 0; n < k; n++) begin
          s = {1'b0, acc0} + {1'b0, 64'(Am[i][n]) * 64'(Bm[n][j])};
          if (SAT && s[64]) begin acc0 = '1; es0 = 1; end
          else acc0 = s[63:0];
          a8s = Am[i][n][7:0];
          b8s = Bm[n][j][7:0];
          acc1 = acc1 + longint'($signed(a8s)) * longint'($signed(b8s));
          if (SAT) begin
            if (acc1 > 32767)       begin acc1 = 32767;  es1 = 1; end
            else if (acc1 < -32768) begin acc1 = -32768; es1 = 1; end
          end else begin
            t16 = acc1[15:0];
            acc1 = longint'($signed(t16));
          end
          acc2 = acc2 + longint'(a8s) * longint'(b8s);
          if (SAT) begin
            if (acc2 > 65535) begin acc2 = 65535; es2 = 1; end
          end else begin
            acc2 = acc2 & 65535;
          end
        end
        e0[i][j] = acc0;
        e1[i][j] = acc1[15:0];
        e2[i][j] = acc2[15:0];
      end
    end
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < R; i++) begin
      for (int j = 0; j < C; j++) begin
        rd_row = 2'(i);
        rd_col = 2'(j);
        @(negedge clk);
        check({tag, "_u0"}, rd0, e0[i][j]);
        check({tag, "_u1"}, 64'(rd1), 64'(e1[i][j]));
        check({tag, "_u2"}, 64'(rd2), 64'(e2[i][j]));
      end
    end
`ifdef SYSARR_SAT_EN
    check({tag, "_sat"}, {sat0, sat1, sat2}, {es0, es1, es2});
`endif
    @(posedge clk); #1;
  endtask

  task automatic fill_random();
    for (int i = 0; i < R; i++) for (int n = 0; n < KMAX; n++) Am[i][n] = $urandom;
    for (int n = 0; n < KMAX; n++) for (int j = 0; j < C; j++) Bm[n][j] = $urandom;
  endtask

  function automatic bit bub_at(input logic [63:0] bub, input int c);
    return (c < 64) ? bub[c] : 1'b0;
  endfunction

  // Runs one product; cycle 0 is the first cycle after start is accepted.
  // Expected timing: done arrives R+C-1 cycles after the cycle of the last
  // accepted beat (or in cycle 0 when k is 0).
  task automatic run_prod(input int k, input logic [63:0] bub, input bit poke, output int obs_done);
    int exp_done, beats, nacc, c;
    bit eb, ed, er;
    if (k == 0) exp_done = 0;
    else begin
      nacc = 0; c = 0;
      while (1) begin
        if (!bub_at(bub, c)) begin
          nacc++;
          if (nacc == k) break;
        end
        c++;
      end
      exp_done = c + R + C - 1;
    end
    model(k);
    start = 1'b1; k_len = 8'(k); in_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    beats = 0;
    obs_done = -1;
`ifdef SYSARR_SAT_EN
    check("sat_cleared", {sat0, sat1, sat2}, 3'b000);
`endif
    for (int cyc = 0; cyc <= exp_done + 1; cyc++) begin
      eb = (k > 0) && (cyc < exp_done);
      ed = (cyc == exp_done);
      er = (k > 0) && (beats < k);
      check("busy", busy0, eb);
      check("done", done0, ed);
      check("in_ready", in_ready0, er);
      check("ctl_u12", {busy1, done1, in_ready1, busy2, done2, in_ready2}, {eb, ed, er, eb, ed, er});
      if (done0 && obs_done < 0) obs_done = cyc;
      for (int i = 0; i < R; i++) a32[i*32 +: 32] = $urandom;
      for (int j = 0; j < C; j++) b32[j*32 +: 32] = $urandom;
      if (k > 0 && beats < k) begin
        in_valid = !bub_at(bub, cyc);
        if (in_valid) begin
          for (int i = 0; i < R; i++) a32[i*32 +: 32] = Am[i][beats];
          for (int j = 0; j < C; j++) b32[j*32 +: 32] = Bm[beats][j];
        end
      end else begin
        in_valid = 1'($urandom);
      end
      start = poke && (cyc == 1 || cyc == exp_done);
      if (start) k_len = 8'($urandom_range(1, 9));
      @(posedge clk); #1;
      if (in_valid && k > 0 && beats < k) beats++;
    end
    start = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    int od;
    logic [63:0] bub;
    rst = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0;
    a32 = '0; b32 = '0; rd_row = '0; rd_col = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctl_u0", {busy0, done0, in_ready0}, 3'b000);
    check("rst_ctl_u12", {busy1, done1, in_ready1, busy2, done2, in_ready2}, 6'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    model(0);
    read_all("rst");

    // All A = 1, all B = 2, K = 4
    for (int i = 0; i < R; i++) for (int n = 0; n < KMAX; n++) Am[i][n] = 32'd1;
    for (int n = 0; n < KMAX; n++) for (int j = 0; j < C; j++) Bm[n][j] = 32'd2;
    run_prod(4, '0, 1'b0, od);
    check("ones_done_cycle", 64'(od), 64'd10);
    read_all("ones");
    rd_row = 2'd3; rd_col = 2'd3;
    @(negedge clk);
    check("ones_cell33", rd0, 64'd8);
    @(posedge clk); #1;

    // Identity A, B[k][j] = 4k+j+1
    for (int i = 0; i < R; i++) for (int n = 0; n < KMAX; n++) Am[i][n] = (i == n) ? 32'd1 : 32'd0;
    for (int n = 0; n < KMAX; n++) for (int j = 0; j < C; j++) Bm[n][j] = 32'(4*n + j + 1);
    run_prod(4, '0, 1'b0, od);
    check("ident_done_cycle", 64'(od), 64'd10);
    read_all("ident");

    // Same stimulus with bubbles on cycles 1, 2 and 5
    bub = '0; bub[1] = 1'b1; bub[2] = 1'b1; bub[5] = 1'b1;
    run_prod(4, bub, 1'b0, od);
    check("bubble_done_cycle", 64'(od), 64'd13);
    read_all("bubble");
    rd_row = 2'd2; rd_col = 2'd1;
    @(negedge clk);
    check("bubble_cell21", rd0, 64'd10);
    @(posedge clk); #1;

    // Signed: row 0 = {-3, 4}, col 0 = {5, -2}
    fill_random();
    Am[0][0] = 32'hFFFF_FFFD; Am[0][1] = 32'd4;
    Bm[0][0] = 32'd5;         Bm[1][0] = 32'hFFFF_FFFE;
    run_prod(2, '0, 1'b0, od);
    read_all("signed");
    rd_row = 2'd0; rd_col = 2'd0;
    @(negedge clk);
    check("signed_cell00", 64'(rd1), 64'h0000_0000_0000_FFE9);
    @(posedge clk); #1;

    // All operands 255, K = 2: 130050 exceeds 16 bits
    for (int i = 0; i < R; i++) for (int n = 0; n < KMAX; n++) Am[i][n] = 32'd255;
    for (int n = 0; n < KMAX; n++) for (int j = 0; j < C; j++) Bm[n][j] = 32'd255;
    run_prod(2, '0, 1'b0, od);
    read_all("big");
    rd_row = 2'd1; rd_col = 2'd2;
    @(negedge clk);
    check("big_cell12", 64'(rd2), SAT ? 64'hFFFF : 64'hFC02);
    repeat (5) @(posedge clk);
    #1;
`ifdef SYSARR_SAT_EN
    check("sat_sticky", sat2, 1'b1);
`endif

    // start poked during LOAD and DONE must be ignored
    fill_random();
    run_prod(5, '0, 1'b1, od);
    check("poke_done_cycle", 64'(od), 64'd11);
    read_all("poke");

    // k_len = 0
    run_prod(0, '0, 1'b0, od);
    check("k0_done_cycle", 64'(od), 64'd0);
    read_all("k0");

    // Reset while draining
    fill_random();
    start = 1'b1; k_len = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 0; n < 3; n++) begin
      in_valid = 1'b1;
      for (int i = 0; i < R; i++) a32[i*32 +: 32] = Am[i][n];
      for (int j = 0; j < C; j++) b32[j*32 +: 32] = Bm[n][j];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("drain_busy", {busy0, in_ready0}, 2'b10);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    check("rst_abort_busy", {busy0, busy1, busy2}, 3'b000);
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      check("rst_abort_done", {done0, done1, done2}, 3'b000);
    end
    model(0);
    read_all("rst_abort");

    // Randomised products with random bubbles
    for (int t = 0; t < 8; t++) begin
      fill_random();
      bub = {$urandom, $urandom} & {$urandom, $urandom};
      run_prod($urandom_range(1, 12), bub, t[0], od);
      read_all("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/systolic_array_param.md
Name: systolic_array_param

Overview:
- Parametrised ROWS x COLS output-stationary systolic matrix-multiply engine: computes C = A x B, with A of size ROWS x K and B of size K x COLS.
- K is runtime-programmable.
- Successor to the fixed 4x4 array: adds internal input skewing, a start/valid/ready/done handshake, a bubble-tolerant feed, signed mode and an addressable result read port.
- Sits between the operand feeder (one A column and one B row per beat) and downstream result consumers.

Parameters:
- ROWS, 4, PE rows; also the number of A lanes.
- COLS, 4, PE columns; also the number of B lanes.
- DW, 32, operand width.
- ACC_W, 64, accumulator width; must be >= 2*DW.
- KW, 8, width of k_len.
- SIGNED_MODE, 0, 0 = unsigned operands, 1 = two's-complement operands and accumulators.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begin a new product; sampled in IDLE only.
- k_len  in  KW  inner dimension K; sampled with start.
- in_valid  in  1  feeder beat valid.
- in_ready  out  1  array accepts a beat; high only in LOAD.
- a_col  in  ROWS*DW  A[i][k] in lane i, bits [i*DW +: DW], unskewed.
- b_row  in  COLS*DW  B[k][j] in lane j, bits [j*DW +: DW], unskewed.
- busy  out  1  high in LOAD and DRAIN.
- done  out  1  one-cycle pulse when all results are final.
- rd_row  in  clog2(ROWS)  result read row.
- rd_col  in  clog2(COLS)  result read column.
- rd_data  out  ACC_W  combinational accumulator of PE(rd_row, rd_col).

Behaviour:
- Reset: state IDLE; all accumulators, skew registers and PE pass registers 0; in_ready=0, busy=0, done=0; beat and drain counters 0. Reset mid-operation aborts immediately; no done is produced.
- PE: identical to the existing block. Registered east/south pass-through; acc <= acc + a*b on each edge, using the combinational ports.
- Product width: 2*DW, zero- or sign-extended (per SIGNED_MODE) to ACC_W. Accumulation wraps modulo 2^ACC_W.
- Skew: A lane i is delayed by i registers and B lane j by j registers before entering the edge PEs.
- Bubbles: a cycle without a handshake injects 0 into every skew input. Alignment is preserved because A and B traverse equal total delay to every PE. Zero products leave the accumulators unchanged.
- FSM:
  - IDLE: in_ready=0. On start with k_len>0: clear all accumulators, latch k_len, go to LOAD. On start with k_len==0: clear accumulators, go to DONE. Without start, stay in IDLE.
  - LOAD: in_ready=1; a beat is accepted when in_valid && in_ready. After the k_len-th accepted beat, go to DRAIN with the drain counter = ROWS+COLS-2.
  - DRAIN: feed zeros; decrement the counter each cycle; at 0 go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Latency: with no bubbles and the first beat accepted in cycle 0, PE(i,j) accumulates beat k at the end of cycle k+i+j. done is high in cycle k_len+ROWS+COLS-2. Default 4x4 with K=4: cycle 10.
- start is ignored while busy or during DONE.
- Results hold until the next accepted start.
- rd_data is valid whenever the state is IDLE or DONE. During LOAD/DRAIN it shows partial sums and is not guaranteed.

Optional Feature:
- Macro: SYSARR_SAT_EN.
- Defined: each accumulator saturates instead of wrapping.
  - Unsigned mode: clamps at 2^ACC_W-1.
  - Signed mode: clamps at the max/min representable value.
  - A sticky output sat_flag (1 bit) is added, set when any PE clamps; cleared by reset or accepted start.
- Undefined: modulo wrap; no sat_flag port.

Test Plan:
- Default 4x4, K=4, all A=1, all B=2, in_valid held high → every rd_data = 8; done high in exactly cycle 10; busy=1 in cycles 0-9.
- Identity: A = I4, B[k][j] = 4k+j+1 → rd_data(i,j) = 4i+j+1 for all 16 cells.
- Bubbles: same stimulus as the identity test with in_valid low on cycles 1, 2 and 5 → identical results; done delayed by 3 cycles.
- SIGNED_MODE=1, DW=8, ACC_W=16, K=2: A row 0 = {-3, 4}, B col 0 = {5, -2} → rd_data(0,0) = 0xFFE9 (-23).
- Control: start during LOAD is ignored; k_len=0 → accumulators read 0 and done one cycle after start; rst asserted in DRAIN → done never pulses, all rd_data = 0.
- SYSARR_SAT_EN, DW=8, ACC_W=16, unsigned, K=2, all operands 255 → 2*65025 exceeds the range, so rd_data = 0xFFFF and sat_flag = 1 until the next start.
